// File: rtl/display_scan.sv
// Time-multiplexed 4-digit common-anode scan controller with per-slot guard interval and frame-synchronous display update.
// Optional leading-zero suppression on digits 3..1 is enabled by defining LEADING_ZERO_BLANK_EN.
module display_scan #(
    parameter int unsigned PRESCALE = 1000,
    parameter int unsigned GUARD    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  blank,
    input  logic        load,
    output logic        d3,
    output logic        d2,
    output logic        d1,
    output logic        d0,
    output logic [3:0]  an,
    output logic        dp_n,
    output logic        frame_done
);

    typedef enum logic {S_GUARD, S_ACTIVE} state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [15:0] shadow, display, disp_nxt;
    logic [3:0]  dp_shadow, dp_disp, dpd_nxt;
    logic        pending;
    logic        wrap, boundary, lit;
    logic [3:0]  lz, an_nxt, nib_nxt;
    logic        dp_nxt;

    // Outputs are registered from next-state values so they change on the same edge as cnt/idx/state.
    always_comb begin
        wrap      = (cnt == 16'(PRESCALE - 1));
        boundary  = wrap && (idx == 2'd3);
        cnt_nxt   = wrap ? '0 : cnt + 16'd1;
        idx_nxt   = wrap ? idx + 2'd1 : idx;

        state_nxt = state;
        if (wrap)
            state_nxt = S_GUARD;
        else if (cnt_nxt == 16'(GUARD))
            state_nxt = S_ACTIVE;

        disp_nxt = display;
        dpd_nxt  = dp_disp;
        if (boundary) begin
            if (load) begin
                disp_nxt = value;
                dpd_nxt  = dp_in;
            end else if (pending) begin
                disp_nxt = shadow;
                dpd_nxt  = dp_shadow;
            end
        end

`ifdef LEADING_ZERO_BLANK_EN
        lz[3] = (disp_nxt[15:12] == 4'd0);
        lz[2] = lz[3] && (disp_nxt[11:8] == 4'd0);
        lz[1] = lz[2] && (disp_nxt[7:4] == 4'd0);
        lz[0] = 1'b0;
`else
        lz = '0;
`endif

        nib_nxt = disp_nxt[idx_nxt*4 +: 4];
        lit     = (state_nxt == S_ACTIVE) && !blank[idx_nxt] && !lz[idx_nxt];
        an_nxt  = lit ? ~(4'b0001 << idx_nxt) : '1;
        dp_nxt  = lit ? ~dpd_nxt[idx_nxt] : 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= S_GUARD;
            cnt              <= '0;
            idx              <= '0;
            shadow           <= '0;
            dp_shadow        <= '0;
            display          <= '0;
            dp_disp          <= '0;
            pending          <= 1'b0;
            {d3, d2, d1, d0} <= '0;
            an               <= '1;
            dp_n             <= 1'b1;
            frame_done       <= 1'b0;
        end else begin
            state            <= state_nxt;
            cnt              <= cnt_nxt;
            idx              <= idx_nxt;
            display          <= disp_nxt;
            dp_disp          <= dpd_nxt;
            {d3, d2, d1, d0} <= nib_nxt;
            an               <= an_nxt;
            dp_n             <= dp_nxt;
            frame_done       <= boundary;
            if (load) begin
                shadow    <= value;
                dp_shadow <= dp_in;
            end
            // A load on the boundary cycle goes straight to display, so nothing is left pending.
            if (boundary)
                pending <= 1'b0;
            else if (load)
                pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Scoreboard bench for display_scan: a cycle-count model pushes expected outputs at each edge, checked on the falling edge.
module tb_display_scan;

    localparam int P = 8;
    localparam int G = 2;
    localparam int F = 4 * P;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank = '0;
    logic        load = 1'b0;
    logic        d3, d2, d1, d0;
    logic [3:0]  an;
    logic        dp_n;
    logic        frame_done;

    display_scan #(.PRESCALE(P), .GUARD(G)) dut (
        .clk(clk), .rst_n(rst_n), .value(value), .dp_in(dp_in), .blank(blank), .load(load),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .an(an), .dp_n(dp_n), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model state: cycle index since reset release plus display/shadow contents.
    int          m_t = 0;
    logic [15:0] m_disp = '0, m_sh = '0;
    logic [3:0]  m_dpd = '0, m_dpsh = '0;
    logic        m_pend = 1'b0;
    logic [9:0]  q[$];

    function automatic logic lz_sup(input int slot, input logic [15:0] disp);
`ifdef LEADING_ZERO_BLANK_EN
        if (slot == 0) return 1'b0;
        return (disp >> (4 * slot)) == 16'd0;
`else
        return 1'b0;
`endif
    endfunction

    initial forever begin : model
        logic       bnd, lit;
        int         pos, slot;
        logic [3:0] nib, exp_an;
        @(posedge clk);
        if (rst_n) begin
            bnd = (m_t % F) == F - 1;
            if (bnd && load) begin
                m_disp = value; m_dpd = dp_in; m_pend = 1'b0;
            end else if (bnd && m_pend) begin
                m_disp = m_sh; m_dpd = m_dpsh; m_pend = 1'b0;
            end
            if (load) begin
                m_sh = value; m_dpsh = dp_in;
                if (!bnd) m_pend = 1'b1;
            end
            m_t++;
            pos    = m_t % P;
            slot   = (m_t / P) % 4;
            lit    = (pos >= G) && !blank[slot] && !lz_sup(slot, m_disp);
            nib    = m_disp[slot*4 +: 4];
            exp_an = lit ? ~(4'b0001 << slot) : 4'hF;
            q.push_back({exp_an, nib, lit ? ~m_dpd[slot] : 1'b1, bnd});
        end
    end

    initial forever begin : scoreboard
        logic [9:0] e;
        @(negedge clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            check("an", 32'(an), 32'(e[9:6]));
            check("digit", 32'({d3, d2, d1, d0}), 32'(e[5:2]));
            check("dp_n", 32'(dp_n), 32'(e[1]));
            check("frame_done", 32'(frame_done), 32'(e[0]));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_slot(input int target);
        for (int i = 0; i < 2 * F && (m_t % F) != target; i++) step(1);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
        value = v; dp_in = dp; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_an"}, 32'(an), 32'hF);
        check({tag, "_digit"}, 32'({d3, d2, d1, d0}), 32'h0);
        check({tag, "_dp_n"}, 32'(dp_n), 32'h1);
        check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        m_t = 0; m_disp = '0; m_sh = '0; m_dpd = '0; m_dpsh = '0; m_pend = 1'b0;
        q.delete();
        step(3);
        rst_n = 1'b1;
        check_reset_outputs("rst_release");
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin : driver
        step(1);
        apply_reset();
        step(40);

        wait_slot(10);
        do_load(16'h1A5F, 4'b0000);
        step(60);

        wait_slot(5);
        do_load(16'h1234, 4'b1000);
        wait_slot(20);
        do_load(16'hBEEF, 4'b0001);
        step(50);

        wait_slot(F - 1);
        do_load(16'hC0DE, 4'b0100);
        step(70);

        blank = 4'b0100;
        do_load(16'h5678, 4'b0010);
        step(70);
        blank = 4'b0000;

        do_load(16'h9ABC, 4'b1111);
        wait_slot(20);
        check("pre_rst_an", 32'(an), 32'hB);
        apply_reset();
        step(40);

        do_load(16'h0070, 4'b0000);
        step(70);
        do_load(16'h0000, 4'b0001);
        step(70);
        do_load(16'h0305, 4'b0000);
        step(70);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
